// File: rtl/btb_update_queue.sv
// Mispredict resolution queue feeding the BTB write port: coalesces repeated
// PCs in place, drains one entry per cycle, and counts pushes dropped when full.
package mmm_pkg;
    parameter int unsigned XLEN = 32;
endpackage

module btb_update_queue
    import mmm_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      res_valid_i,
    input  logic                      res_mispredict_i,
    input  logic                      res_taken_i,
    input  logic [XLEN-1:0]           res_pc_i,
    input  logic [XLEN-1:0]           res_target_i,
    input  logic                      upd_ready_i,
    output logic                      update_valid_o,
    output logic                      del_entry_o,
    output logic [XLEN-1:0]           res_pc_o,
    output logic [XLEN-1:0]           res_target_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o,
    output logic [7:0]                drop_cnt_o
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CW   = PTRW + 1;

    logic            taken_q  [DEPTH];
    logic [XLEN-1:0] pc_q     [DEPTH];
    logic [XLEN-1:0] target_q [DEPTH];
    logic            taken_d  [DEPTH];
    logic [XLEN-1:0] pc_d     [DEPTH];
    logic [XLEN-1:0] target_d [DEPTH];

    logic [PTRW-1:0] head_q, head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic            pop;
    logic            cand;
    logic            alloc;
    logic            drop;
    logic            any_match;
    logic [PTRW-1:0] match_idx;
    logic [PTRW-1:0] offset;

    always_comb begin
        pop       = (count_q != '0) && upd_ready_i;
        cand      = res_valid_i && res_mispredict_i;
        any_match = 1'b0;
        match_idx = '0;
        offset    = '0;

        // An entry is live when its distance from head is below count; a popping
        // head is excluded so a repeat of its PC allocates a fresh entry.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PTRW'(i) - head_q;
            if ((CW'(offset) < count_q) && (pc_q[i] == res_pc_i) &&
                !(pop && (PTRW'(i) == head_q))) begin
                any_match = 1'b1;
                match_idx = PTRW'(i);
            end
        end

        alloc = cand && !any_match && ((count_q != CW'(DEPTH)) || pop) && !flush_i;
        drop  = cand && !any_match && (count_q == CW'(DEPTH)) && !pop && !flush_i;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            taken_d[i]  = taken_q[i];
            pc_d[i]     = pc_q[i];
            target_d[i] = target_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            if (cand && any_match) begin
                taken_d[match_idx]  = res_taken_i;
                target_d[match_idx] = res_target_i;
            end else if (alloc) begin
                taken_d[tail_q]  = res_taken_i;
                pc_d[tail_q]     = res_pc_i;
                target_d[tail_q] = res_target_i;
                tail_d           = tail_q + 1'b1;
            end
            if (alloc && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !alloc) begin
                count_d = count_q - 1'b1;
            end
        end

        overflow_d = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                taken_q[i]  <= 1'b0;
                pc_q[i]     <= '0;
                target_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                taken_q[i]  <= taken_d[i];
                pc_q[i]     <= pc_d[i];
                target_q[i] <= target_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        update_valid_o = (count_q != '0);
        del_entry_o    = 1'b0;
        res_pc_o       = '0;
        res_target_o   = '0;
        if (count_q != '0) begin
            del_entry_o  = !taken_q[head_q];
            res_pc_o     = pc_q[head_q];
            res_target_o = target_q[head_q];
        end
        count_o    = count_q;
        overflow_o = overflow_q;
        drop_cnt_o = drop_cnt_q;
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed and randomized checks of btb_update_queue against a queue-based
// model of the resolution buffer.
module tb_btb_update_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            res_valid_i;
    logic            res_mispredict_i;
    logic            res_taken_i;
    logic [XLEN-1:0] res_pc_i;
    logic [XLEN-1:0] res_target_i;
    logic            upd_ready_i;
    logic            update_valid_o;
    logic            del_entry_o;
    logic [XLEN-1:0] res_pc_o;
    logic [XLEN-1:0] res_target_o;
    logic [2:0]      count_o;
    logic            overflow_o;
    logic [7:0]      drop_cnt_o;

    btb_update_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .res_valid_i(res_valid_i), .res_mispredict_i(res_mispredict_i),
        .res_taken_i(res_taken_i), .res_pc_i(res_pc_i), .res_target_i(res_target_i),
        .upd_ready_i(upd_ready_i), .update_valid_o(update_valid_o),
        .del_entry_o(del_entry_o), .res_pc_o(res_pc_o), .res_target_o(res_target_o),
        .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } ent_t;

    ent_t        mq[$];
    int unsigned mdrop;
    bit          movf;
    int unsigned tests;
    int unsigned fails;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mdrop = 0;
        movf  = 0;
    endtask

    // Spec rules in order: flush wins; otherwise the pop leaves first, then
    // the candidate coalesces into, appends to, or is rejected by what remains.
    task automatic model_step();
        int found;
        movf = 0;
        if (flush_i) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && upd_ready_i) void'(mq.pop_front());
            if (res_valid_i && res_mispredict_i) begin
                found = -1;
                foreach (mq[k]) if (mq[k].pc == res_pc_i) found = k;
                if (found >= 0) begin
                    mq[found].taken  = res_taken_i;
                    mq[found].target = res_target_i;
                end else if (mq.size() < DEPTH) begin
                    mq.push_back('{res_taken_i, res_pc_i, res_target_i});
                end else begin
                    movf = 1;
                    if (mdrop < 255) mdrop++;
                end
            end
        end
    endtask

    task automatic check_all();
        bit nz;
        nz = (mq.size() != 0);
        chk("update_valid", update_valid_o, nz);
        chk("del_entry", del_entry_o, nz ? !mq[0].taken : 1'b0);
        chk("res_pc", res_pc_o, nz ? mq[0].pc : '0);
        chk("res_target", res_target_o, nz ? mq[0].target : '0);
        chk("count", count_o, mq.size());
        chk("overflow", overflow_o, movf);
        chk("drop_cnt", drop_cnt_o, mdrop);
    endtask

    task automatic step(input bit v, input bit m, input bit t, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] tg, input bit rdy, input bit fl);
        res_valid_i      = v;
        res_mispredict_i = m;
        res_taken_i      = t;
        res_pc_i         = pc;
        res_target_i     = tg;
        upd_ready_i      = rdy;
        flush_i          = fl;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        check_all();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_i = 1'b1;
        flush_i = 0; res_valid_i = 0; res_mispredict_i = 0; res_taken_i = 0;
        res_pc_i = '0; res_target_i = '0; upd_ready_i = 0;
        model_reset();
        #2;
        check_all();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // basic push then pop
        step(1, 1, 1, 32'h100, 32'h200, 1, 0);
        chk("basic_pc", res_pc_o, 32'h100);
        chk("basic_tgt", res_target_o, 32'h200);
        step(0, 0, 0, '0, '0, 1, 0);
        chk("basic_empty", count_o, 0);

        // coalesce
        step(1, 1, 1, 32'h100, 32'h200, 0, 0);
        step(1, 1, 1, 32'h104, 32'h500, 0, 0);
        step(1, 1, 0, 32'h100, 32'h300, 0, 0);
        chk("coal_count", count_o, 2);
        chk("coal_del", del_entry_o, 1);
        chk("coal_tgt", res_target_o, 32'h300);
        step(0, 0, 0, '0, '0, 1, 0);
        chk("coal_second", res_pc_o, 32'h104);
        step(0, 0, 0, '0, '0, 1, 0);

        // overflow
        for (int i = 0; i < 5; i++) step(1, 1, 1, 32'h200 + 32'(i * 4), 32'h1000 + 32'(i), 0, 0);
        chk("ovf_count", count_o, 4);
        chk("ovf_pulse", overflow_o, 1);
        chk("ovf_drop", drop_cnt_o, 1);
        step(0, 0, 0, '0, '0, 0, 0);
        chk("ovf_pulse_end", overflow_o, 0);

        // full with simultaneous pop
        step(1, 1, 1, 32'h300, 32'h3000, 1, 0);
        chk("fullpop_count", count_o, 4);
        chk("fullpop_ovf", overflow_o, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, '0, 1, 0);

        // flush and non-mispredict
        for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h400 + 32'(i * 4), 32'h44, 0, 0);
        step(1, 1, 1, 32'h500, 32'h55, 0, 1);
        chk("flush_count", count_o, 0);
        chk("flush_drop", drop_cnt_o, 1);
        step(1, 0, 1, 32'h600, 32'h66, 0, 0);
        chk("nomisp_count", count_o, 0);

        // drop counter saturation
        for (int i = 0; i < 264; i++) step(1, 1, 1, 32'h8000 + 32'(i * 4), 32'(i), 0, 0);
        chk("drop_sat", drop_cnt_o, 255);
        step(0, 0, 0, '0, '0, 0, 1);

        // randomized traffic over a small PC set to provoke coalescing
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 32'h100 + 32'($urandom_range(0, 6) * 4), $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
        end

        // async reset mid-drain
        step(0, 0, 0, '0, '0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h700 + 32'(i * 4), 32'h77, 0, 0);
        step(0, 0, 0, '0, '0, 1, 0);
        chk("pre_rst_count", count_o, 2);
        #1 rst_i = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk_i);
        rst_i = 1'b0;
        step(0, 0, 0, '0, '0, 1, 0);
        chk("post_rst_valid", update_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Buffers branch resolutions from the execute stage and drains them, one per cycle, into the BTB write port (`update_valid_i`, `del_entry_i`, `res_pc_i`, `res_target_i` of the BTB). It decouples the execute stage, which never stalls, from BTB write arbitration.
- Only mispredicted resolutions are enqueued.
- Repeated resolutions of the same PC are coalesced in place.
- Overflow drops the new resolution and is counted, never back-pressured.

## Interface
- `DEPTH`, 4, queue entries; power of two, ≥ 2.
- `XLEN`, from `mmm_pkg`, PC/target width.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: synchronous clear of queue contents.
- `res_valid_i` in 1: execute-stage resolution valid this cycle.
- `res_mispredict_i` in 1: resolution was mispredicted; enqueue only when `res_valid_i & res_mispredict_i`.
- `res_taken_i` in 1: 1 means write entry (taken), 0 means delete entry.
- `res_pc_i` in XLEN: branch PC.
- `res_target_i` in XLEN: resolved target.
- `upd_ready_i` in 1: BTB write port free this cycle.
- `update_valid_o` out 1: head entry presented to BTB.
- `del_entry_o` out 1: head is a delete (`!taken`).
- `res_pc_o` out XLEN: head PC.
- `res_target_o` out XLEN: head target.
- `count_o` out $clog2(DEPTH)+1: occupied entries.
- `overflow_o` out 1: one-cycle pulse, registered, when a push was dropped.
- `drop_cnt_o` out 8: saturating count of dropped pushes.

## Operation
- **Storage:** circular buffer of {`taken`, `pc`, `target`}, with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- **Outputs:** `update_valid_o` = (count ≠ 0). `del_entry_o`, `res_pc_o` and `res_target_o` come from the head entry when non-empty and are forced to 0 when empty.
- **Pop:** `update_valid_o & upd_ready_i`. The head advances and count decrements.
- **Push candidate:** `res_valid_i & res_mispredict_i`.
- **Coalesce:** the candidate PC is compared against every valid entry. The head entry is excluded from the comparison when it pops this cycle.
  - On a match, the matching entry's `taken` and `target` are overwritten. There is no allocation and no count change.
  - At most one entry can match, since coalescing keeps PCs unique.
- **Allocate:** taken when there is no match and (count < DEPTH or a pop occurs this cycle). The entry is written at the tail and the tail advances.
- **Drop:** no match, count == DEPTH and no pop.
  - The candidate is discarded.
  - `overflow_o` = 1 in the next cycle.
  - `drop_cnt_o` increments and saturates at 255.
- **Count update:** +1 on allocate without pop, −1 on pop without allocate, unchanged otherwise.
- **`flush_i`:** has priority over push and pop.
  - Head, tail and count are cleared. A coincident push is discarded and not counted as a drop.
  - `drop_cnt_o` and `overflow_o` are not cleared by flush.
- **`rst_i`:** clears all state (pointers, count, entries, `drop_cnt_o`, `overflow_o`) immediately and asynchronously. Reset value of every output is 0.

## Timing
- **Latency:** a push into an empty queue is presented on `update_valid_o` the cycle after `res_valid_i`, i.e. 1-cycle latency. There is no same-cycle bypass.
- **Throughput:** one push and one pop per cycle, sustained.
- **Head changes:** an entry that is presented stays stable until popped. The only exception is an in-place coalesce onto a head that is not popping, which updates `del_entry_o`/`res_target_o` in the following cycle.
- **Full with simultaneous pop:** the push is accepted and count stays at DEPTH.
- **Coalesce-target timing:** visible on the outputs in the cycle after the push.
- **Reset mid-operation:** pending updates are lost. `update_valid_o` falls asynchronously with `rst_i` and stays 0 until the first push after reset deassertion.
- **`drop_cnt_o`:** updates one cycle after the drop, together with `overflow_o`.

## Test plan
- **Basic push/pop:** reset, then push pc=0x100, target=0x200, taken=1 with `upd_ready_i`=1.
  - Expect `update_valid_o`=1, `res_pc_o`=0x100, `res_target_o`=0x200, `del_entry_o`=0 for exactly one cycle, starting the cycle after the push.
  - Then expect count_o=0.
- **Coalesce:** with `upd_ready_i`=0, push pc=0x100/target 0x200, then pc=0x104, then pc=0x100/target 0x300 taken=0.
  - Expect count_o=2.
  - Release `upd_ready_i`: expect pops of (0x100, del=1, target 0x300) then (0x104).
- **Overflow:** with `upd_ready_i`=0, push 5 distinct PCs with DEPTH=4.
  - Expect count_o=4, `overflow_o` pulses once, `drop_cnt_o`=1.
  - The drained order is the first 4 PCs.
- **Full with simultaneous pop:** at count=4, push a new PC with `upd_ready_i`=1.
  - Expect count_o stays 4, no overflow, and the new PC is drained last.
- **Flush and non-mispredict:**
  - Fill 3 entries, then assert `flush_i` together with a push: expect count_o=0, `update_valid_o`=0 next cycle, and `drop_cnt_o` unchanged.
  - Push with `res_mispredict_i`=0: expect no enqueue.
- **Async reset:** assert `rst_i` mid-drain with 2 entries pending.
  - Expect all outputs 0 immediately, before any clock edge, and `drop_cnt_o`=0.
